// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher that owns the architectural PC.
// Optional FETCH_MISALIGN_TRAP_EN: a redirect to a target with bit 1 set traps into HALT instead of being aligned down.
// state   | meaning
// IDLE    | post-reset bubble, no request
// FETCH   | request to imem (or a one-cycle gap after a same-cycle redirect)
// HOLD    | word valid, waiting for decode to accept
// DISCARD | draining the stale response of a redirected fetch
// HALT    | misaligned redirect trapped (only with the macro)
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        PCSrc,
  input  logic        Jalr,
  input  logic [31:0] pc_target,
  input  logic [31:0] jalr_target,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        misalign
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_HOLD    = 3'd2;
  localparam logic [2:0] ST_DISCARD = 3'd3;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [2:0] ST_HALT    = 3'd4;
`endif

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        gap_q, gap_d;
  logic [31:0] tgt_raw, tgt;

  assign tgt_raw = Jalr ? {jalr_target[31:1], 1'b0} : pc_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic unused_jalr_lsb;
  assign tgt             = tgt_raw;
  assign unused_jalr_lsb = jalr_target[0];
  assign misalign        = misalign_q;
`else
  logic unused_tgt_bits;
  assign tgt             = {tgt_raw[31:2], 2'b00};
  assign unused_tgt_bits = ^{jalr_target[0], tgt_raw[1:0]};
  assign misalign        = 1'b0;
`endif

  assign pc_plus4    = pc_q + 32'd4;
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  // gap_q suppresses the request for the cycle after a redirect that coincided with rvalid
  assign imem_req    = (state_q == ST_FETCH) && !gap_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    gap_d   = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (PCSrc) begin
          pc_d = tgt;
          if (!gap_q) begin
            if (imem_rvalid) gap_d = 1'b1;
            else             state_d = ST_DISCARD;
          end
        end else if (imem_rvalid && !gap_q) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (PCSrc) begin
          pc_d    = tgt;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = ST_FETCH;
        end else if (instr_ready) begin
          pc_d    = pc_plus4;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (PCSrc)       pc_d    = tgt;
        if (imem_rvalid) state_d = ST_FETCH;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    if (PCSrc && tgt[1] &&
        (state_q == ST_FETCH || state_q == ST_HOLD || state_q == ST_DISCARD)) begin
      state_d    = ST_HALT;
      pc_d       = tgt;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      gap_d      = 1'b0;
      misalign_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      gap_q   <= gap_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against an imem model
// and a PC-sequence reference (next PC = redirect target, or PC+4 on acceptance).
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_rvalid = 1'b0;
  logic        PCSrc = 1'b0;
  logic        Jalr = 1'b0;
  logic [31:0] pc_target = 32'h0;
  logic [31:0] jalr_target = 32'h0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        misalign;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .PCSrc(PCSrc), .Jalr(Jalr), .pc_target(pc_target), .jalr_target(jalr_target),
    .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .misalign(misalign)
  );

  int          vectors = 0;
  int          errors = 0;
  logic [31:0] exp_pc = 32'h0;
  logic        halted = 1'b0;
  logic        valid_now = 1'b0;
  logic        busy = 1'b0;
  int          cnt = 0;
  int          lat = 1;
  logic        rand_lat = 1'b0;
  logic [31:0] mem_addr = 32'h0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Apply the reference update for the coming edge, then sample mid-cycle and run the memory.
  task automatic tick();
    logic [31:0] t;
    if (!reset) begin
      exp_pc = 32'h0;
      halted = 1'b0;
    end else if (!halted) begin
      if (PCSrc) begin
        t = Jalr ? {jalr_target[31:1], 1'b0} : pc_target;
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_pc = t;
        if (t[1]) halted = 1'b1;
`else
        exp_pc = {t[31:2], 2'b00};
`endif
      end else if (valid_now && instr_ready) begin
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(negedge clk);
    valid_now   = instr_valid;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (!reset) begin
      busy = 1'b0;
    end else if (busy) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memfn(mem_addr);
        busy        = 1'b0;
      end
    end else if (imem_req) begin
      busy     = 1'b1;
      mem_addr = imem_addr;
      cnt      = rand_lat ? int'($urandom_range(1, 4)) : lat;
    end
    check32("pc", pc, exp_pc);
    check32("pc_plus4", pc_plus4, exp_pc + 32'd4);
    check32("instr", instr, instr_valid ? memfn(exp_pc) : NOP);
    check1("misalign", misalign, halted);
    if (imem_req) check32("imem_addr", imem_addr, exp_pc);
    if (halted) check1("halt_req", imem_req, 1'b0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (instr_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check1(tag, instr_valid, 1'b1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check1(tag, imem_req, 1'b1);
  endtask

  task automatic reset_cycle();
    reset = 1'b0;
    PCSrc = 1'b0;
    instr_ready = 1'b0;
    tick();
    tick();
    check1("rst_req", imem_req, 1'b0);
    check32("rst_pc", pc, 32'h0);
    check32("rst_instr", instr, NOP);
    check1("rst_valid", instr_valid, 1'b0);
    check1("rst_misalign", misalign, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    int idle;
    logic stalled;

    // reset release and first fetch, latency 1
    reset_cycle();
    tick();
    check1("req_cycle1", imem_req, 1'b0);
    tick();
    check1("req_cycle2", imem_req, 1'b1);
    check32("addr_cycle2", imem_addr, 32'h0);
    tick();
    check1("valid_on_rvalid_cycle", instr_valid, 1'b0);
    tick();
    check1("valid_after_rvalid", instr_valid, 1'b1);
    check32("first_instr", instr, 32'h0050_0093);

    // stall in HOLD for 5 cycles, then accept
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("hold_valid", instr_valid, 1'b1);
      check32("hold_instr", instr, 32'h0050_0093);
      check32("hold_pc", pc, 32'h0);
      check1("hold_req", imem_req, 1'b0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check1("accept_req", imem_req, 1'b1);
    check32("accept_addr", imem_addr, 32'h4);
    wait_valid("wait_pc4");

    // redirect in FETCH without rvalid -> DISCARD
    lat = 3;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    PCSrc = 1'b1; Jalr = 1'b0; pc_target = 32'h40;
    tick();
    PCSrc = 1'b0;
    lat = 1;
    check1("discard_req", imem_req, 1'b0);
    check32("discard_pc", pc, 32'h40);
    wait_req("discard_reissue");
    check32("discard_addr", imem_addr, 32'h40);
    wait_valid("wait_pc40");
    check32("instr_40", instr, memfn(32'h40));

    // redirect beats ready in HOLD, JALR clears bit 0
    PCSrc = 1'b1; Jalr = 1'b1; jalr_target = 32'h81; instr_ready = 1'b1;
    tick();
    PCSrc = 1'b0; Jalr = 1'b0; instr_ready = 1'b0;
    check32("jalr_pc", pc, 32'h80);
    check1("jalr_req", imem_req, 1'b1);
    check32("jalr_addr", imem_addr, 32'h80);
    check1("jalr_valid", instr_valid, 1'b0);
    wait_valid("wait_pc80");

    // PC wrap
    PCSrc = 1'b1; pc_target = 32'hFFFF_FFFC;
    tick();
    PCSrc = 1'b0;
    wait_valid("wait_pc_top");
    check32("top_pc", pc, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check1("wrap_req", imem_req, 1'b1);
    check32("wrap_addr", imem_addr, 32'h0);

    // redirect coinciding with rvalid: one-cycle request gap
    tick();
    check1("coinc_rvalid", imem_rvalid, 1'b1);
    PCSrc = 1'b1; pc_target = 32'h200;
    tick();
    PCSrc = 1'b0;
    check1("gap_req", imem_req, 1'b0);
    check32("gap_pc", pc, 32'h200);
    check1("gap_valid", instr_valid, 1'b0);
    tick();
    check1("reissue_req", imem_req, 1'b1);
    check32("reissue_addr", imem_addr, 32'h200);
    wait_valid("wait_pc200");

    // misaligned JALR target
    PCSrc = 1'b1; Jalr = 1'b1; jalr_target = 32'h0000_0106;
    tick();
    PCSrc = 1'b0; Jalr = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    check1("trap_misalign", misalign, 1'b1);
    check32("trap_pc", pc, 32'h106);
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("trap_req", imem_req, 1'b0);
      check1("trap_sticky", misalign, 1'b1);
    end
`else
    check1("align_misalign", misalign, 1'b0);
    check32("align_pc", pc, 32'h104);
    check1("align_req", imem_req, 1'b1);
    check32("align_addr", imem_addr, 32'h104);
`endif

    // randomized run from a fresh reset
    reset_cycle();
    tick();
    tick();
    rand_lat = 1'b1;
    idle = 0;
    stalled = 1'b0;
    for (int i = 0; i < 3000 && !stalled; i++) begin
      tick();
      if (instr_valid) idle = 0;
      else             idle++;
      if (idle > 300) stalled = 1'b1;
      PCSrc       = ($urandom_range(0, 15) == 0);
      Jalr        = 1'($urandom_range(0, 1));
      instr_ready = 1'($urandom_range(0, 1));
`ifdef FETCH_MISALIGN_TRAP_EN
      pc_target   = $urandom & 32'hFFFF_FFFC;
      jalr_target = $urandom & 32'hFFFF_FFFD;
`else
      pc_target   = $urandom;
      jalr_target = $urandom;
`endif
    end
    PCSrc = 1'b0;
    check1("liveness", stalled, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
